// File: rtl/mem_pkg.sv
// Shared types and constants for the instruction/data SRAM arbiter.
package mem_pkg;

  // Which requester owns the read data returning this cycle.
  typedef enum logic [1:0] {
    RSP_NONE,
    RSP_IF,
    RSP_D
  } rsp_owner_t;

  // Byte enables used for every read and every fetch.
  localparam logic [3:0] MEM_BE_ALL = 4'b1111;

  // Width of the data-grant streak counter (holds MAX_D_STREAK up to 15).
  localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and SRAM port seen by the arbiter.
interface mem_arbiter_if;

  // Fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;

  // Load/store port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;

  // SRAM port
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;

  // Core plus SRAM side: drives requests and SRAM read data.
  modport master (
    output if_req, if_addr,
    output d_req, d_we, d_addr, d_wdata, d_be,
    output mem_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    input  mem_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and
// load/store. Data wins contention; a streak counter forces fetch in after
// MAX_D_STREAK consecutive data grants taken while fetch was waiting.
// Read data returns one cycle after grant, tagged to the issuing requester.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q, streak_d;
  rsp_owner_t          rsp_q, rsp_d;
  logic                if_gnt, d_gnt;

  // Grant decision: data first unless fetch has been starved long enough.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!rst) begin
      if (bus.d_req && (!bus.if_req || (streak_q < MaxStreak))) begin
        d_gnt = 1'b1;
      end else if (bus.if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  // Next streak count and next response owner.
  always_comb begin
    streak_d = streak_q;
    if (if_gnt || !bus.if_req) begin
      streak_d = '0;
    end else if (d_gnt) begin
      // Cannot wrap: a data grant with fetch waiting implies streak_q < MaxStreak.
      streak_d = streak_q + 1'b1;
    end

    rsp_d = RSP_NONE;
    if (if_gnt) begin
      rsp_d = RSP_IF;
    end else if (d_gnt && !bus.d_we) begin
      rsp_d = RSP_D;
    end
  end

  // SRAM command driven from whichever requester holds the grant.
  always_comb begin
    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.mem_en    = if_gnt | d_gnt;
    bus.mem_we    = d_gnt & bus.d_we;
    bus.mem_addr  = d_gnt ? {bus.d_addr[31:2], 2'b00} : {bus.if_addr[31:2], 2'b00};
    bus.mem_wdata = d_gnt ? bus.d_wdata : '0;
    bus.mem_be    = (d_gnt && bus.d_we) ? bus.d_be : MEM_BE_ALL;
  end

  // Responses; masking with rst drops a read whose data lands during reset.
  always_comb begin
    bus.if_rvalid = (rsp_q == RSP_IF) && !rst;
    bus.d_rvalid  = (rsp_q == RSP_D) && !rst;
    bus.if_rdata  = bus.mem_rdata;
    bus.d_rdata   = bus.mem_rdata;
  end

  // Streak counter and response owner state.
  always_ff @(posedge clk) begin
    if (rst) begin
      streak_q <= '0;
      rsp_q    <= RSP_NONE;
    end else begin
      streak_q <= streak_d;
      rsp_q    <= rsp_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: an SRAM model, a shadow-memory reference
// model checked every cycle, and hand-computed literal expectations.
module tb_mem_arbiter;

  localparam int unsigned MaxD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .MAX_D_STREAK(MaxD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h1122_3344 : 32'hA000_0000 + 32'(i);
  endfunction

  // SRAM model: reloaded while rst is high, byte-enabled writes, 1-cycle reads.
  logic [31:0] sram[64];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) sram[i] <= init_word(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.mem_be[b]) sram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      end else begin
        bus.mem_rdata <= sram[bus.mem_addr[7:2]];
      end
    end
  end

  // Reference model state.
  logic [31:0] shadow[64];
  int          m_streak  = 0;
  int          pend_own  = 0;  // 0 none, 1 fetch, 2 data
  logic [31:0] pend_data = '0;
  bit          logging   = 1'b0;
  byte         glog[$];

  // Every cycle: check responses from last cycle, then this cycle's grant and command.
  always @(negedge clk) begin
    bit          e_if, e_d;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    int          idx;

    chk("if_rvalid", 32'(bus.if_rvalid), 32'(pend_own == 1 && !rst));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(pend_own == 2 && !rst));
    if (pend_own == 1 && !rst) chk("if_rdata", bus.if_rdata, pend_data);
    if (pend_own == 2 && !rst) chk("d_rdata", bus.d_rdata, pend_data);

    e_if = 1'b0;
    e_d  = 1'b0;
    if (!rst) begin
      if (bus.d_req && (!bus.if_req || m_streak < int'(MaxD))) e_d = 1'b1;
      else if (bus.if_req) e_if = 1'b1;
    end
    chk("if_gnt", 32'(bus.if_gnt), 32'(e_if));
    chk("d_gnt", 32'(bus.d_gnt), 32'(e_d));
    chk("mem_en", 32'(bus.mem_en), 32'(e_if | e_d));

    if (e_if || e_d) begin
      e_addr = e_d ? bus.d_addr : bus.if_addr;
      e_addr[1:0] = 2'b00;
      e_be = (e_d && bus.d_we) ? bus.d_be : 4'hF;
      chk("mem_addr", bus.mem_addr, e_addr);
      chk("mem_we", 32'(bus.mem_we), 32'(e_d && bus.d_we));
      chk("mem_be", 32'(bus.mem_be), 32'(e_be));
      if (e_d && bus.d_we) chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
    end

    if (logging) glog.push_back(e_d ? "D" : (e_if ? "F" : "-"));

    // Advance the model to the next cycle.
    pend_own = 0;
    if (rst) begin
      for (int i = 0; i < 64; i++) shadow[i] = init_word(i);
      m_streak = 0;
    end else begin
      idx = int'(e_d ? bus.d_addr[7:2] : bus.if_addr[7:2]);
      if (e_d && bus.d_we) begin
        for (int b = 0; b < 4; b++)
          if (bus.d_be[b]) shadow[idx][8*b +: 8] = bus.d_wdata[8*b +: 8];
      end else if (e_d || e_if) begin
        pend_own  = e_if ? 1 : 2;
        pend_data = shadow[idx];
      end
      if (e_if || !bus.if_req) m_streak = 0;
      else if (e_d) m_streak++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    bus.d_we   = 1'b0;
  endtask

  initial begin
    string exp_pat;
    int    cnt;
    bit    found;

    idle();
    bus.if_addr = '0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
    bus.d_be    = '0;
    repeat (3) cyc();
    rst = 1'b0;
    #2;
    chk("reset_rvalid", 32'({bus.if_rvalid, bus.d_rvalid}), 32'd0);
    chk("reset_mem_en", 32'(bus.mem_en), 32'd0);
    cyc();

    // Fetch stream 0x0, 0x4, 0x8.
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0;
    cyc();
    chk("fetch_w0", bus.if_rvalid ? bus.if_rdata : 32'hDEAD, 32'hA000_0000);
    bus.if_addr = 32'h4;
    cyc();
    chk("fetch_w1", bus.if_rvalid ? bus.if_rdata : 32'hDEAD, 32'hA000_0001);
    bus.if_addr = 32'h8;
    cyc();
    chk("fetch_w2", bus.if_rvalid ? bus.if_rdata : 32'hDEAD, 32'hA000_0002);
    idle();
    cyc();

    // Partial store then load back.
    bus.d_req = 1'b1;
    bus.d_we = 1'b1;
    bus.d_addr = 32'h10;
    bus.d_wdata = 32'hAABB_CCDD;
    bus.d_be = 4'b0011;
    #2;
    chk("store_we_be", 32'({bus.mem_we, bus.mem_be}), 32'h13);
    cyc();
    bus.d_we = 1'b0;
    cyc();
    idle();
    chk("load_after_store", bus.d_rvalid ? bus.d_rdata : 32'hDEAD, 32'h1122_CCDD);
    cyc();

    // Misaligned address bits ignored.
    bus.d_req = 1'b1;
    bus.d_addr = 32'h1F;
    #2;
    chk("addr_align", bus.mem_addr, 32'h1C);
    cyc();
    idle();
    cyc();

    // Contention, 12 cycles.
    bus.if_req = 1'b1;
    bus.if_addr = 32'h20;
    bus.d_req = 1'b1;
    bus.d_addr = 32'h24;
    logging = 1'b1;
    repeat (12) cyc();
    logging = 1'b0;
    idle();
    cyc();
    exp_pat = "DDDDFDDDDFDD";
    chk("pattern_len", 32'(glog.size()), 32'd12);
    for (int i = 0; i < 12 && i < glog.size(); i++)
      chk("grant_pattern", 32'(glog[i]), 32'(exp_pat[i]));

    // Load stream, fetch joins mid-stream.
    bus.d_req = 1'b1;
    bus.d_addr = 32'h28;
    repeat (3) cyc();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h2C;
    cnt = 0;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      #2;
      if (bus.if_gnt) begin
        found = 1'b1;
      end else begin
        if (bus.d_gnt) cnt++;
        cyc();
      end
    end
    chk("fetch_forced_in", 32'(found), 32'd1);
    chk("streak_dgrants", 32'(cnt), 32'(MaxD));
    cyc();
    idle();
    cyc();

    // Reset while a load is outstanding.
    bus.d_req = 1'b1;
    bus.d_addr = 32'h30;
    #2;
    chk("rst_load_gnt", 32'(bus.d_gnt), 32'd1);
    cyc();
    rst = 1'b1;
    bus.if_req = 1'b1;
    #2;
    chk("rst_drop_rvalid", 32'(bus.d_rvalid), 32'd0);
    chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
    cyc();
    #2;
    chk("rst_mem_en2", 32'(bus.mem_en), 32'd0);
    cyc();
    rst = 1'b0;
    idle();
    #2;
    chk("post_rst_rvalid", 32'(bus.d_rvalid), 32'd0);
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous SRAM between the core's instruction-fetch port and its load/store data port. Each requester uses a request/grant handshake, and the SRAM issues at most one access per cycle. Read data returns exactly one cycle after grant, tagged to the requester that issued it. Data accesses win contention, but a streak counter bounds how long fetch can starve.

## Interface
Parameters:
- MAX_D_STREAK, default 4: consecutive data grants allowed while fetch is waiting before fetch is forced in; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_gnt
- if_addr  in  32  fetch byte address; word aligned; bits [1:0] ignored
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  fetch read data valid (registered)
- if_rdata  out  32  fetch read data; valid only with if_rvalid
- d_req  in  1  data request; held with d_* stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data byte address; bits [1:0] ignored
- d_wdata  in  32  store data, already lane-aligned
- d_be  in  4  store byte enables; ignored for loads
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  load data valid (registered); never asserted for stores
- d_rdata  out  32  load data, full word; the core does extraction and sign extension
- mem_en  out  1  SRAM access this cycle
- mem_we  out  1  SRAM write
- mem_addr  out  32  SRAM byte address, bits [1:0] forced to 0
- mem_wdata  out  32  SRAM write data
- mem_be  out  4  SRAM byte enables; 4'b1111 on every read
- mem_rdata  in  32  SRAM read data, valid the cycle after a read enable

## Operation
- Grant decision is combinational from the requests and the state below:
  - only if_req asserted: grant fetch
  - only d_req asserted: grant data
  - both asserted and streak < MAX_D_STREAK: grant data
  - both asserted and streak == MAX_D_STREAK: grant fetch
- mem_en equals (if_gnt | d_gnt). if_gnt and d_gnt are never high together.
- mem_* fields are driven from the granted requester.
  - Fetch grant: mem_we = 0 and mem_be = 4'b1111.
  - Data store grant: mem_be = d_be. A store with d_be = 0 still issues mem_en with mem_we = 1 and mem_be = 0.
- Streak counter, 4 bits. On a clock edge:
  - d_gnt while if_req is high: increment.
  - if_gnt, or if_req low: clear to 0.
  - otherwise: hold.
- Response owner register rsp_q takes one of RSP_NONE, RSP_IF, RSP_D. At each edge it is set as follows:
  - RSP_IF if the fetch grant was a read.
  - RSP_D if the data grant was a load.
  - RSP_NONE otherwise, including stores and idle cycles.
- Response outputs:
  - if_rvalid = (rsp_q == RSP_IF).
  - d_rvalid = (rsp_q == RSP_D).
  - if_rdata and d_rdata both pass mem_rdata through unregistered.
- Throughput is one access per cycle. A new grant may occur in the same cycle as the previous access's rvalid.

## Timing
- Reset values: rsp_q = RSP_NONE, streak = 0. Consequently:
  - if_rvalid and d_rvalid are 0 in the cycle after reset.
  - Grants, and therefore mem_en, are forced to 0 while rst is high.
- Reset during an outstanding read drops the response. No rvalid is produced for that read even though mem_rdata arrives.
- Read latency is grant cycle N, rvalid cycle N+1. A store completes in its grant cycle.
- Requests are not latched. A requester that drops req before gnt simply withdraws.
- A request may be deasserted in the cycle after its gnt, or re-asserted to issue back-to-back accesses.
- With MAX_D_STREAK = 1 and both requesters held high, grants alternate D, F, D, F.
- Stores do not advance rsp_q. A store followed by a load to the same address returns the new data, because the SRAM write completes before the next read.

## Structure
- Package mem_pkg holds:
  - enum rsp_owner_t {RSP_NONE, RSP_IF, RSP_D}
  - constant MEM_BE_ALL = 4'b1111
  - the streak counter width
- Single module. The grant logic is an always_comb block; the counters and owner live in one always_ff. No sub-module.

## Test plan
- Fetch only, if_req held, if_addr 0x0, 0x4, 0x8 on successive cycles: expect if_gnt every cycle and if_rvalid from cycle 1 carrying SRAM words 0, 1, 2. d_rvalid stays 0.
- Store d_addr 0x10, d_wdata 0xAABBCCDD, d_be 4'b0011, then a load from 0x10 (SRAM preloaded with 0x11223344): expect mem_we = 1 and mem_be = 0011 on the store, then d_rvalid with d_rdata 0x1122CCDD one cycle after the load grant.
- Both requesters held 12 cycles with MAX_D_STREAK = 4: expect grant pattern DDDDF DDDDF DD. if_rvalid and d_rvalid each follow their own grants by one cycle and are never high together.
- Address with bits [1:0] = 2'b11 (0x1F): expect mem_addr 0x1C.
- Load granted at cycle N, rst high at N+1: expect d_rvalid 0 at N+1 and after, and mem_en 0 while rst is high.
- Stream of loads with if_req low, then if_req rising mid-stream: expect the streak to start at 0 and fetch to be granted after exactly MAX_D_STREAK further data grants.
